// File: rtl/decode_stage_if.sv
// Fetch->decode->execute handshake bundle: fetch side (valid/ready, instr, pc,
// flush) and the registered decode outputs presented to execute.
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic            isALUimm;
   logic            isALUreg;
   logic            isBranch;
   logic            isJAL;
   logic            isJALR;
   logic            isLUI;
   logic            isAUIPC;
   logic            isLoad;
   logic            isStore;
   logic            isSystem;
   logic [7:0]      funct3oh;
   logic [6:0]      funct7;
   logic [4:0]      rd_addr;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [31:0]     imm;
   logic            illegal;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc,
      input  isALUimm, isALUreg, isBranch, isJAL, isJALR,
      input  isLUI, isAUIPC, isLoad, isStore, isSystem,
      input  funct3oh, funct7, rd_addr, rs1_addr, rs2_addr,
      input  imm, illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc,
      output isALUimm, isALUreg, isBranch, isJAL, isJALR,
      output isLUI, isAUIPC, isLoad, isStore, isSystem,
      output funct3oh, funct7, rd_addr, rs1_addr, rs2_addr,
      output imm, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes {instr,pc} and holds it in an output register
// backed by a skid register. Ports: clk, rst (async, active high), io (slave).
module decode_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic          clk,
   input logic          rst,
   decode_stage_if.slave io
);

   typedef struct packed {
      logic        alu_imm;
      logic        alu_reg;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        lui;
      logic        auipc;
      logic        load;
      logic        store;
      logic        system;
      logic [7:0]  f3oh;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        ill;
   } dec_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      dec_t            d;
   } ent_t;

   localparam ent_t RST_ENT = '{pc: RESET_PC, d: '0};

   logic [31:0] w;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] imm_sh;
   logic [7:0]  f3oh;
   logic        ill;
   dec_t        dec;

   assign w  = io.in_instr;
   assign op = w[6:0];
   assign f3 = w[14:12];
   assign f7 = w[31:25];

   assign imm_i  = {{20{w[31]}}, w[31:20]};
   assign imm_s  = {{20{w[31]}}, w[31:25], w[11:7]};
   assign imm_b  = {{20{w[31]}}, w[7], w[30:25],
                    w[11:8], 1'b0};
   assign imm_u  = {w[31:12], 12'h000};
   assign imm_j  = {{12{w[31]}}, w[19:12], w[20],
                    w[30:21], 1'b0};
   assign imm_sh = {27'h0, w[24:20]};
   assign f3oh   = 8'h01 << f3;

   always_comb begin
      dec     = '0;
      dec.rd  = w[11:7];
      dec.rs1 = w[19:15];
      dec.rs2 = w[24:20];
      ill     = 1'b0;
      unique case (1'b1)
         (op == 7'b0010011): begin
            dec.alu_imm = 1'b1;
            dec.f3oh    = f3oh;
            if (f3 == 3'b001) begin
               dec.f7  = f7;
               dec.imm = imm_sh;
               ill     = (f7 != 7'h00);
            end else if (f3 == 3'b101) begin
               dec.f7  = f7;
               dec.imm = imm_sh;
               ill     = (f7 != 7'h00) && (f7 != 7'h20);
            end else begin
               // non-shift: funct7 stays 0 so the ALU never sees SUB/SRA
               dec.imm = imm_i;
            end
         end
         (op == 7'b0110011): begin
            dec.alu_reg = 1'b1;
            dec.f3oh    = f3oh;
            dec.f7      = f7;
            ill = !((f7 == 7'h00) ||
                    ((f7 == 7'h20) &&
                     ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         (op == 7'b1100011): begin
            dec.branch = 1'b1;
            dec.f3oh   = f3oh;
            dec.imm    = imm_b;
            ill        = (f3 == 3'b010) || (f3 == 3'b011);
         end
         (op == 7'b1101111): begin
            dec.jal = 1'b1;
            dec.imm = imm_j;
         end
         (op == 7'b1100111): begin
            dec.jalr = 1'b1;
            dec.f3oh = f3oh;
            dec.imm  = imm_i;
            ill      = (f3 != 3'b000);
         end
         (op == 7'b0110111): begin
            dec.lui = 1'b1;
            dec.imm = imm_u;
         end
         (op == 7'b0010111): begin
            dec.auipc = 1'b1;
            dec.imm   = imm_u;
         end
         (op == 7'b0000011): begin
            dec.load = 1'b1;
            dec.f3oh = f3oh;
            dec.imm  = imm_i;
            ill      = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         (op == 7'b0100011): begin
            dec.store = 1'b1;
            dec.f3oh  = f3oh;
            dec.imm   = imm_s;
            ill       = (f3 > 3'b010);
         end
         (op == 7'b1110011): begin
            dec.system = 1'b1;
            dec.f3oh   = f3oh;
            dec.imm    = imm_i;
         end
         (op == 7'b0001111): begin
            // FENCE: legal, no execute flag of its own
            dec.f3oh = f3oh;
            dec.imm  = imm_i;
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         dec     = '0;
         dec.rd  = w[11:7];
         dec.rs1 = w[19:15];
         dec.rs2 = w[24:20];
         dec.ill = 1'b1;
      end
   end

   ent_t or_q, or_d;
   ent_t sr_q, sr_d;
   logic or_valid_q, or_valid_d;
   logic sr_valid_q, sr_valid_d;
   logic in_ready;
   logic accept;
   logic consume;
   ent_t ent;

   // ready depends only on skid state, never on out_ready
   assign in_ready = !rst && !sr_valid_q;
   assign accept   = io.in_valid && in_ready && !io.flush;
   assign consume  = or_valid_q && io.out_ready;
   assign ent      = '{pc: io.in_pc, d: dec};

   always_comb begin
      or_d       = or_q;
      sr_d       = sr_q;
      or_valid_d = or_valid_q;
      sr_valid_d = sr_valid_q;
      if (io.flush) begin
         or_d       = RST_ENT;
         sr_d       = '0;
         or_valid_d = 1'b0;
         sr_valid_d = 1'b0;
      end else if (!or_valid_q || consume) begin
         if (sr_valid_q) begin
            or_d       = sr_q;
            or_valid_d = 1'b1;
            sr_valid_d = 1'b0;
         end else if (accept) begin
            or_d       = ent;
            or_valid_d = 1'b1;
         end else begin
            or_valid_d = 1'b0;
         end
      end else if (accept) begin
         sr_d       = ent;
         sr_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         or_q       <= RST_ENT;
         sr_q       <= '0;
         or_valid_q <= 1'b0;
         sr_valid_q <= 1'b0;
      end else begin
         or_q       <= or_d;
         sr_q       <= sr_d;
         or_valid_q <= or_valid_d;
         sr_valid_q <= sr_valid_d;
      end
   end

   assign io.in_ready  = in_ready;
   assign io.out_valid = or_valid_q;
   assign io.out_pc    = or_q.pc;
   assign io.isALUimm  = or_q.d.alu_imm;
   assign io.isALUreg  = or_q.d.alu_reg;
   assign io.isBranch  = or_q.d.branch;
   assign io.isJAL     = or_q.d.jal;
   assign io.isJALR    = or_q.d.jalr;
   assign io.isLUI     = or_q.d.lui;
   assign io.isAUIPC   = or_q.d.auipc;
   assign io.isLoad    = or_q.d.load;
   assign io.isStore   = or_q.d.store;
   assign io.isSystem  = or_q.d.system;
   assign io.funct3oh  = or_q.d.f3oh;
   assign io.funct7    = or_q.d.f7;
   assign io.rd_addr   = or_q.d.rd;
   assign io.rs1_addr  = or_q.d.rs1;
   assign io.rs2_addr  = or_q.d.rs2;
   assign io.imm       = or_q.d.imm;
   assign io.illegal   = or_q.d.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: reference decoder plus an in-order
// queue model of the two-entry stage; directed spec vectors and stalls.
module tb_decode_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32)) io();

   decode_stage #(
      .XLEN(32),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io(io)
   );

   typedef struct packed {
      logic [10:0] flags;
      logic [7:0]  f3oh;
      logic [6:0]  f7;
      logic [14:0] regs;
      logic [31:0] imm;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] w;
   } txn_t;

   txn_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic check(string tag, logic [63:0] got,
                        logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference decoder: format and legality per opcode
   function automatic exp_t model(logic [31:0] w);
      exp_t        e;
      logic [6:0]  op = w[6:0];
      logic [2:0]  f3 = w[14:12];
      logic [6:0]  f7 = w[31:25];
      logic [9:0]  kind = '0;
      bit          ok = 1'b1;
      bit          use_f3 = 1'b1;
      bit          keep_f7 = 1'b0;
      logic [31:0] im = '0;
      logic [31:0] i_imm = 32'($signed(w[31:20]));
      case (op)
         7'h13: begin
            kind = 10'b10_0000_0000;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               keep_f7 = 1'b1;
               im = {27'd0, w[24:20]};
               ok = (f7 == 7'h00) ||
                    (f3 == 3'd5 && f7 == 7'h20);
            end else im = i_imm;
         end
         7'h33: begin
            kind = 10'b01_0000_0000;
            keep_f7 = 1'b1;
            ok = (f7 == 7'h00) ||
                 (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         end
         7'h63: begin
            kind = 10'b00_1000_0000;
            im = 32'($signed({w[31], w[7], w[30:25],
                              w[11:8], 1'b0}));
            ok = !(f3 == 3'd2 || f3 == 3'd3);
         end
         7'h6f: begin
            kind = 10'b00_0100_0000;
            use_f3 = 1'b0;
            im = 32'($signed({w[31], w[19:12], w[20],
                              w[30:21], 1'b0}));
         end
         7'h67: begin
            kind = 10'b00_0010_0000;
            im = i_imm;
            ok = (f3 == 3'd0);
         end
         7'h37: begin
            kind = 10'b00_0001_0000;
            use_f3 = 1'b0;
            im = {w[31:12], 12'h000};
         end
         7'h17: begin
            kind = 10'b00_0000_1000;
            use_f3 = 1'b0;
            im = {w[31:12], 12'h000};
         end
         7'h03: begin
            kind = 10'b00_0000_0100;
            im = i_imm;
            ok = (f3 != 3'd3) && (f3 < 3'd6);
         end
         7'h23: begin
            kind = 10'b00_0000_0010;
            im = 32'($signed({w[31:25], w[11:7]}));
            ok = (f3 <= 3'd2);
         end
         7'h73: begin
            kind = 10'b00_0000_0001;
            im = i_imm;
         end
         7'h0f: im = i_imm;
         default: ok = 1'b0;
      endcase
      e.flags = ok ? {kind, 1'b0} : 11'd1;
      e.f3oh  = (ok && use_f3) ? (8'd1 << f3) : 8'd0;
      e.f7    = (ok && keep_f7) ? f7 : 7'd0;
      e.imm   = ok ? im : 32'd0;
      e.regs  = {w[11:7], w[19:15], w[24:20]};
      return e;
   endfunction

   function automatic exp_t dut_view();
      exp_t g;
      g.flags = {io.isALUimm, io.isALUreg, io.isBranch,
                 io.isJAL, io.isJALR, io.isLUI, io.isAUIPC,
                 io.isLoad, io.isStore, io.isSystem,
                 io.illegal};
      g.f3oh  = io.funct3oh;
      g.f7    = io.funct7;
      g.regs  = {io.rd_addr, io.rs1_addr, io.rs2_addr};
      g.imm   = io.imm;
      return g;
   endfunction

   // One clock: check at negedge, advance model, return at posedge+1
   task automatic step();
      exp_t e;
      exp_t g;
      bit   fo;
      bit   fi;
      @(negedge clk);
      check("out_valid", 64'(io.out_valid), 64'(q.size() > 0));
      check("in_ready", 64'(io.in_ready), 64'(q.size() < 2));
      if (io.out_valid && q.size() > 0) begin
         e = model(q[0].w);
         g = dut_view();
         check("out_pc", 64'(io.out_pc), 64'(q[0].pc));
         check("flags", 64'(g.flags), 64'(e.flags));
         check("funct3oh", 64'(g.f3oh), 64'(e.f3oh));
         check("funct7", 64'(g.f7), 64'(e.f7));
         check("regs", 64'(g.regs), 64'(e.regs));
         check("imm", 64'(g.imm), 64'(e.imm));
      end
      fo = io.out_valid && io.out_ready;
      fi = io.in_valid && io.in_ready && !io.flush;
      if (io.flush) q.delete();
      else begin
         if (fo && q.size() > 0) void'(q.pop_front());
         if (fi) q.push_back('{io.in_pc, io.in_instr});
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int          k = $urandom_range(0, 15);
      logic [6:0]  ops [11] = '{7'h13, 7'h33, 7'h63, 7'h6f,
                                7'h67, 7'h37, 7'h17, 7'h03,
                                7'h23, 7'h73, 7'h0f};
      if (k < 11) w[6:0] = ops[k];
      if (w[6:0] == 7'h33 ||
          (w[6:0] == 7'h13 && w[13:12] == 2'b01)) begin
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
         endcase
      end
      if (k == 15) w = 32'h0;
      return w;
   endfunction

   localparam int ND = 9;
   logic [31:0] d_w   [ND] = '{32'hFFB10093, 32'h40725193,
                               32'h407302B3, 32'hFE20FEE3,
                               32'h00000000, 32'h027302B3,
                               32'hFFFFF0B7, 32'h40109093,
                               32'hFFF17093};
   logic [2:0]  d_fl  [ND] = '{3'b100, 3'b100, 3'b010, 3'b001,
                               3'b000, 3'b000, 3'b000, 3'b000,
                               3'b100};
   logic [7:0]  d_f3  [ND] = '{8'h01, 8'h20, 8'h01, 8'h80,
                               8'h00, 8'h00, 8'h00, 8'h00,
                               8'h80};
   logic [6:0]  d_f7  [ND] = '{7'h00, 7'h20, 7'h20, 7'h00,
                               7'h00, 7'h00, 7'h00, 7'h00,
                               7'h00};
   logic [31:0] d_imm [ND] = '{32'hFFFFFFFB, 32'h7, 32'h0,
                               32'hFFFFFFFC, 32'h0, 32'h0,
                               32'hFFFFF000, 32'h0,
                               32'hFFFFFFFF};
   logic        d_ill [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      logic [31:0] r;
      rst          = 1'b1;
      io.in_valid  = 1'b0;
      io.in_instr  = '0;
      io.in_pc     = '0;
      io.flush     = 1'b0;
      io.out_ready = 1'b0;
      #12;
      check("rst_in_ready", 64'(io.in_ready), 64'd0);
      check("rst_out_valid", 64'(io.out_valid), 64'd0);
      check("rst_out_pc", 64'(io.out_pc), 64'(RESET_PC));
      check("rst_imm", 64'(io.imm), 64'd0);
      check("rst_flags", 64'(dut_view().flags), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_in_ready", 64'(io.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // directed vectors, one at a time
      for (int i = 0; i < ND; i++) begin
         io.out_ready = 1'b1;
         io.in_valid  = 1'b1;
         io.in_instr  = d_w[i];
         io.in_pc     = 32'h1000 + 32'(i * 4);
         step();
         io.in_valid = 1'b0;
         check("d_valid", 64'(io.out_valid), 64'd1);
         check("d_pc", 64'(io.out_pc),
               64'(32'h1000 + 32'(i * 4)));
         check("d_flags", 64'({io.isALUimm, io.isALUreg,
                               io.isBranch}), 64'(d_fl[i]));
         check("d_f3oh", 64'(io.funct3oh), 64'(d_f3[i]));
         check("d_f7", 64'(io.funct7), 64'(d_f7[i]));
         check("d_imm", 64'(io.imm), 64'(d_imm[i]));
         check("d_ill", 64'(io.illegal), 64'(d_ill[i]));
         step();
      end

      // stall: A,B accepted, C refused, then drain with no bubbles
      io.out_ready = 1'b0;
      io.in_valid  = 1'b1;
      io.in_instr  = 32'hFFB10093;
      io.in_pc     = 32'h200;
      step();
      io.in_instr  = 32'h40725193;
      io.in_pc     = 32'h204;
      step();
      check("stall_in_ready", 64'(io.in_ready), 64'd0);
      io.in_instr  = 32'h407302B3;
      io.in_pc     = 32'h208;
      step();
      check("stall_hold_pc", 64'(io.out_pc), 64'h200);
      io.out_ready = 1'b1;
      step();
      check("drain_b", 64'({io.out_valid, io.out_pc}),
            64'({1'b1, 32'h204}));
      step();
      io.in_valid = 1'b0;
      check("drain_c", 64'({io.out_valid, io.out_pc}),
            64'({1'b1, 32'h208}));
      step();
      check("drain_empty", 64'(io.out_valid), 64'd0);

      // flush mid-stall
      io.out_ready = 1'b0;
      io.in_valid  = 1'b1;
      io.in_instr  = 32'hFE20FEE3;
      io.in_pc     = 32'h300;
      step();
      io.in_pc     = 32'h304;
      step();
      io.in_pc     = 32'h308;
      io.flush     = 1'b1;
      step();
      io.flush     = 1'b0;
      io.in_valid  = 1'b0;
      check("flush_valid", 64'(io.out_valid), 64'd0);
      check("flush_ready", 64'(io.in_ready), 64'd1);
      io.out_ready = 1'b1;
      repeat (3) step();

      // randomized traffic
      repeat (3000) begin
         r = $urandom;
         io.in_valid  = ($urandom_range(0, 9) < 7);
         io.in_instr  = rand_instr();
         io.in_pc     = r & ~32'h3;
         io.out_ready = ($urandom_range(0, 9) < 6);
         io.flush     = ($urandom_range(0, 49) == 0);
         step();
      end
      io.in_valid  = 1'b0;
      io.flush     = 1'b0;
      io.out_ready = 1'b1;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
